// File: rtl/store_narrow_pkg.sv
// Shared definitions for the store path: access-size encodings (also used by the
// load-side extender), FSM states and small decode helpers.
package store_narrow_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_SEND = 2'b01,
        ST_DONE = 2'b10,
        ST_ERR  = 2'b11
    } state_e;

    // Index of the final byte lane for a given access size.
    function automatic logic [1:0] last_idx(input size_e size);
        case (size)
            SIZE_HALF: last_idx = 2'd1;
            SIZE_WORD: last_idx = 2'd3;
            default:   last_idx = 2'd0;
        endcase
    endfunction

    function automatic logic misaligned(input size_e size, input logic [1:0] addr_lo);
        case (size)
            SIZE_HALF: misaligned = addr_lo[0];
            SIZE_WORD: misaligned = (addr_lo != 2'b00);
            default:   misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_narrow_if.sv
// Bundles the store request port, the byte-wide memory write port and the
// done/err status pulses. slave = the store unit, master = CPU/memory side.
interface store_narrow_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic              mem_wvalid;
    logic              mem_wready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              done;
    logic              err;

    modport master (
        output req_valid, req_addr, req_data, req_size, mem_wready,
        input  req_ready, mem_wvalid, mem_addr, mem_wdata, done, err
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_size, mem_wready,
        output req_ready, mem_wvalid, mem_addr, mem_wdata, done, err
    );
endinterface

// File: rtl/store_narrow_byte_select.sv
// Combinational 32->8 lane mux: picks byte idx of a little-endian word.
module store_narrow_byte_select (
    input  logic [31:0] word,
    input  logic [1:0]  idx,
    output logic [7:0]  lane
);
    logic [7:0] lanes [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign lanes[gi] = word[8*gi +: 8];
    end

    assign lane = lanes[idx];
endmodule

// File: rtl/store_narrow.sv
// Narrows a register value to byte/half/word and writes it out one byte per
// handshake, lowest address first, with one-cycle done/err completion pulses.
module store_narrow
    import store_narrow_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter bit ALIGN_CHECK = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    store_narrow_if.slave bus
);
    state_e            state_reg;
    logic [ADDR_W-1:0] base_reg;
    logic [31:0]       data_reg;
    logic [1:0]        idx_reg;
    logic [1:0]        last_reg;

    size_e       req_size;
    logic        reject;
    logic [31:0] lane_src;
    logic [1:0]  lane_sel;
    logic [7:0]  lane_byte;

    assign req_size = size_e'(bus.req_size);
    assign reject   = (req_size == SIZE_ILL) ||
                      (ALIGN_CHECK && misaligned(req_size, bus.req_addr[1:0]));

    // Outputs are registered, so the mux always looks one byte ahead: byte 0 of
    // the incoming request while idle, otherwise the lane after the current one.
    always_comb begin
        lane_src = data_reg;
        lane_sel = idx_reg + 2'd1;
        if (state_reg == ST_IDLE) begin
            lane_src = bus.req_data;
            lane_sel = 2'd0;
        end
    end

    store_narrow_byte_select u_byte_select (
        .word (lane_src),
        .idx  (lane_sel),
        .lane (lane_byte)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            base_reg       <= '0;
            data_reg       <= '0;
            idx_reg        <= '0;
            last_reg       <= '0;
            bus.req_ready  <= 1'b1;
            bus.mem_wvalid <= 1'b0;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.done       <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        base_reg      <= bus.req_addr;
                        data_reg      <= bus.req_data;
                        idx_reg       <= 2'd0;
                        last_reg      <= last_idx(req_size);
                        bus.req_ready <= 1'b0;
                        if (reject) begin
                            state_reg <= ST_ERR;
                            bus.err   <= 1'b1;
                        end else begin
                            state_reg      <= ST_SEND;
                            bus.mem_wvalid <= 1'b1;
                            bus.mem_addr   <= bus.req_addr;
                            bus.mem_wdata  <= lane_byte;
                        end
                    end
                end
                ST_SEND: begin
                    if (bus.mem_wready) begin
                        if (idx_reg == last_reg) begin
                            state_reg      <= ST_DONE;
                            bus.mem_wvalid <= 1'b0;
                            bus.done       <= 1'b1;
                        end else begin
                            idx_reg       <= idx_reg + 2'd1;
                            bus.mem_addr  <= base_reg + ADDR_W'(lane_sel);
                            bus.mem_wdata <= lane_byte;
                        end
                    end
                end
                ST_DONE: begin
                    state_reg     <= ST_IDLE;
                    bus.done      <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                ST_ERR: begin
                    state_reg     <= ST_IDLE;
                    bus.err       <= 1'b0;
                    bus.req_ready <= 1'b1;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_store_narrow.sv
// Directed bench for store_narrow: instance 0 checks alignment, instance 1 does not.
module tb_store_narrow;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    store_narrow_if #(.ADDR_W(32)) bus_a ();
    store_narrow_if #(.ADDR_W(32)) bus_b ();

    store_narrow #(.ADDR_W(32), .ALIGN_CHECK(1'b1)) u_dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    store_narrow #(.ADDR_W(32), .ALIGN_CHECK(1'b0)) u_dut_b (.clk(clk), .reset(reset), .bus(bus_b));

    logic        req_valid_v [2];
    logic [31:0] req_addr_v  [2];
    logic [31:0] req_data_v  [2];
    logic [1:0]  req_size_v  [2];
    logic        wready_v    [2];
    logic        obs_ready   [2];
    logic        obs_wvalid  [2];
    logic [31:0] obs_addr    [2];
    logic [7:0]  obs_wdata   [2];
    logic        obs_done    [2];
    logic        obs_err     [2];

    assign bus_a.req_valid  = req_valid_v[0];
    assign bus_a.req_addr   = req_addr_v[0];
    assign bus_a.req_data   = req_data_v[0];
    assign bus_a.req_size   = req_size_v[0];
    assign bus_a.mem_wready = wready_v[0];
    assign bus_b.req_valid  = req_valid_v[1];
    assign bus_b.req_addr   = req_addr_v[1];
    assign bus_b.req_data   = req_data_v[1];
    assign bus_b.req_size   = req_size_v[1];
    assign bus_b.mem_wready = wready_v[1];

    assign obs_ready[0]  = bus_a.req_ready;
    assign obs_wvalid[0] = bus_a.mem_wvalid;
    assign obs_addr[0]   = bus_a.mem_addr;
    assign obs_wdata[0]  = bus_a.mem_wdata;
    assign obs_done[0]   = bus_a.done;
    assign obs_err[0]    = bus_a.err;
    assign obs_ready[1]  = bus_b.req_ready;
    assign obs_wvalid[1] = bus_b.mem_wvalid;
    assign obs_addr[1]   = bus_b.mem_addr;
    assign obs_wdata[1]  = bus_b.mem_wdata;
    assign obs_done[1]   = bus_b.done;
    assign obs_err[1]    = bus_b.err;

    int checks = 0;
    int errors = 0;

    // Results of the most recent run_store call.
    int          nwr, nhold, hold_bad, done_cnt, err_cnt, done_cyc, err_cyc, rdy_cyc;
    logic [31:0] wa [8];
    logic [7:0]  wd [8];
    int          wc [8];
    logic [31:0] hold_addr;
    logic [7:0]  hold_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic expect_write(input int i, input logic [31:0] addr, input logic [7:0] data, input int cyc);
        check($sformatf("wr%0d_addr", i), wa[i], addr);
        check($sformatf("wr%0d_data", i), wd[i], data);
        check($sformatf("wr%0d_cycle", i), wc[i], cyc);
    endtask

    // Issues one request (accept = cycle 0) and records handshakes, stall holds
    // and status pulses per cycle until req_ready returns.
    task automatic run_store(input int inst, input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] size, input int stall);
        int stall_left;
        stall_left = stall;
        nwr = 0; nhold = 0; hold_bad = 0; done_cnt = 0; err_cnt = 0;
        done_cyc = -1; err_cyc = -1; rdy_cyc = -1;
        @(negedge clk);
        check("idle_ready", obs_ready[inst], 1);
        req_valid_v[inst] = 1'b1;
        req_addr_v[inst]  = addr;
        req_data_v[inst]  = data;
        req_size_v[inst]  = size;
        wready_v[inst]    = 1'b1;
        @(negedge clk);
        req_valid_v[inst] = 1'b0;
        for (int cyc = 1; cyc <= 30 && rdy_cyc < 0; cyc++) begin
            if (cyc > 1) @(negedge clk);
            wready_v[inst] = (stall_left == 0);
            if (obs_wvalid[inst]) begin
                if (stall_left == 0) begin
                    if (nwr < 8) begin
                        wa[nwr] = obs_addr[inst];
                        wd[nwr] = obs_wdata[inst];
                        wc[nwr] = cyc;
                    end
                    nwr++;
                end else begin
                    if (nhold == 0) begin
                        hold_addr = obs_addr[inst];
                        hold_data = obs_wdata[inst];
                    end else if (hold_addr !== obs_addr[inst] || hold_data !== obs_wdata[inst]) begin
                        hold_bad++;
                    end
                    nhold++;
                    stall_left--;
                end
            end
            if (obs_done[inst]) begin
                if (done_cnt == 0) done_cyc = cyc;
                done_cnt++;
            end
            if (obs_err[inst]) begin
                if (err_cnt == 0) err_cyc = cyc;
                err_cnt++;
            end
            if (obs_ready[inst]) rdy_cyc = cyc;
        end
        wready_v[inst] = 1'b1;
        check("ready_returns", (rdy_cyc >= 0), 1);
        $display("txn inst=%0d addr=%08h data=%08h size=%0d stall=%0d: writes=%0d holds=%0d done@%0d err@%0d ready@%0d",
                 inst, addr, data, size, stall, nwr, nhold, done_cyc, err_cyc, rdy_cyc);
    endtask

    initial begin
        int quiet_bad;
        for (int i = 0; i < 2; i++) begin
            req_valid_v[i] = 1'b0;
            req_addr_v[i]  = '0;
            req_data_v[i]  = '0;
            req_size_v[i]  = 2'b00;
            wready_v[i]    = 1'b1;
        end
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready",  obs_ready[0], 1);
        check("rst_wvalid", obs_wvalid[0], 0);
        check("rst_addr",   obs_addr[0], 0);
        check("rst_wdata",  obs_wdata[0], 0);
        check("rst_done",   obs_done[0], 0);
        check("rst_err",    obs_err[0], 0);
        reset = 1'b0;

        // Byte store: single write, done on cycle 2, ready on cycle 3.
        run_store(0, 32'h0000_0100, 32'hDEAD_BEEF, 2'b00, 0);
        check("byte_nwr", nwr, 1);
        expect_write(0, 32'h100, 8'hEF, 1);
        check("byte_done_cyc", done_cyc, 2);
        check("byte_done_cnt", done_cnt, 1);
        check("byte_rdy_cyc", rdy_cyc, 3);
        check("byte_err_cnt", err_cnt, 0);

        // Word store: four consecutive little-endian writes.
        run_store(0, 32'h0000_0200, 32'h1122_3344, 2'b10, 0);
        check("word_nwr", nwr, 4);
        expect_write(0, 32'h200, 8'h44, 1);
        expect_write(1, 32'h201, 8'h33, 2);
        expect_write(2, 32'h202, 8'h22, 3);
        expect_write(3, 32'h203, 8'h11, 4);
        check("word_done_cyc", done_cyc, 5);
        check("word_done_cnt", done_cnt, 1);
        check("word_rdy_cyc", rdy_cyc, 6);

        // Half store with three wait states on the first byte.
        run_store(0, 32'h0000_0010, 32'hFFFF_ABCD, 2'b01, 3);
        check("half_nhold", nhold, 3);
        check("half_hold_addr", hold_addr, 32'h10);
        check("half_hold_data", hold_data, 8'hCD);
        check("half_hold_stable", hold_bad, 0);
        check("half_nwr", nwr, 2);
        expect_write(0, 32'h10, 8'hCD, 4);
        expect_write(1, 32'h11, 8'hAB, 5);
        check("half_done_cyc", done_cyc, 6);
        check("half_done_cnt", done_cnt, 1);

        // Rejections: misaligned word, misaligned half, illegal size.
        run_store(0, 32'h0000_0202, 32'h1234_5678, 2'b10, 0);
        check("mis_word_err_cyc", err_cyc, 1);
        check("mis_word_err_cnt", err_cnt, 1);
        check("mis_word_wvalid", nwr + nhold, 0);
        check("mis_word_done", done_cnt, 0);
        check("mis_word_rdy_cyc", rdy_cyc, 2);
        run_store(0, 32'h0000_0011, 32'h1234_5678, 2'b01, 0);
        check("mis_half_err_cyc", err_cyc, 1);
        check("mis_half_wvalid", nwr + nhold, 0);
        run_store(0, 32'h0000_0100, 32'h1234_5678, 2'b11, 0);
        check("ill_size_err_cyc", err_cyc, 1);
        check("ill_size_err_cnt", err_cnt, 1);
        check("ill_size_wvalid", nwr + nhold, 0);
        run_store(1, 32'h0000_0104, 32'h1234_5678, 2'b11, 0);
        check("ill_size_b_err_cyc", err_cyc, 1);
        check("ill_size_b_wvalid", nwr + nhold, 0);

        // Misaligned word without alignment check wraps past the top of memory.
        run_store(1, 32'hFFFF_FFFE, 32'hAABB_CCDD, 2'b10, 0);
        check("wrap_nwr", nwr, 4);
        expect_write(0, 32'hFFFF_FFFE, 8'hDD, 1);
        expect_write(1, 32'hFFFF_FFFF, 8'hCC, 2);
        expect_write(2, 32'h0000_0000, 8'hBB, 3);
        expect_write(3, 32'h0000_0001, 8'hAA, 4);
        check("wrap_done_cyc", done_cyc, 5);
        check("wrap_err_cnt", err_cnt, 0);
        run_store(0, 32'hFFFF_FFFE, 32'hAABB_CCDD, 2'b10, 0);
        check("wrap_a_err_cyc", err_cyc, 1);
        check("wrap_a_wvalid", nwr + nhold, 0);

        // Reset after the second byte of a word store aborts it silently.
        @(negedge clk);
        req_valid_v[0] = 1'b1;
        req_addr_v[0]  = 32'h0000_0300;
        req_data_v[0]  = 32'hCAFE_F00D;
        req_size_v[0]  = 2'b10;
        wready_v[0]    = 1'b1;
        @(negedge clk);
        req_valid_v[0] = 1'b0;
        check("abort_b0_addr", obs_addr[0], 32'h300);
        check("abort_b0_data", obs_wdata[0], 8'h0D);
        @(negedge clk);
        check("abort_b1_addr", obs_addr[0], 32'h301);
        check("abort_b1_data", obs_wdata[0], 8'hF0);
        @(negedge clk);
        check("abort_b2_wvalid", obs_wvalid[0], 1);
        reset       = 1'b1;
        wready_v[0] = 1'b0;
        @(negedge clk);
        reset       = 1'b0;
        wready_v[0] = 1'b1;
        check("abort_wvalid", obs_wvalid[0], 0);
        check("abort_ready", obs_ready[0], 1);
        check("abort_done", obs_done[0], 0);
        check("abort_addr", obs_addr[0], 0);
        quiet_bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (obs_done[0] || obs_err[0] || obs_wvalid[0]) quiet_bad++;
        end
        check("abort_quiet", quiet_bad, 0);
        $display("txn inst=0 addr=00000300 data=cafef00d size=2 reset after byte 2: quiet_bad=%0d", quiet_bad);

        run_store(0, 32'h0000_0400, 32'h0000_0077, 2'b00, 0);
        check("post_nwr", nwr, 1);
        expect_write(0, 32'h400, 8'h77, 1);
        check("post_done_cyc", done_cyc, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
